dmem_ctrl: RTL and testbench

Parametrised data-memory controller for the multicycle CPU. It replaces the fixed 8-bit/256-entry combinational-read data memory with a single-port array behind a valid/ready request channel and a one-cycle response pulse. It supports configurable data/address width, depth, programmable wait states and out-of-range address detection. It sits between the CPU control FSM (LOAD/STORE states) and the storage array; the CPU stalls until `rsp_valid`.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_array.sv | 43 ++++
 rtl/dmem_ctrl.sv | 135 +++++++++++++
 tb/tb_dmem_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory controller
// Purpose: FSM state encoding, default geometry and wait-counter width.
// Ports: none (package).
package dmem_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_DEPTH       = 256;
    localparam int DEF_WAIT_CYCLES = 1;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port storage with synchronous write and combinational read
// Purpose: DATA_W x DEPTH word array; writes outside the array are suppressed.
// Ports:
//   clk       in   clock
//   we        in   write enable (ignored when addr is out of range)
//   addr      in   word address
//   wdata     in   write data
//   rdata     out  combinational read data (0 when out of range)
//   in_range  out  addr < DEPTH
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              in_range
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2^ADDR_W is representable in the compare.
    localparam logic [ADDR_W:0] DEPTH_X = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;

    assign in_range = ({1'b0, addr} < DEPTH_X);
    assign idx      = addr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = in_range ? mem[idx] : '0;

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - valid/ready data-memory controller with wait states
// Purpose: accepts one LOAD/STORE at a time, inserts wait states, accesses the
//          array on the edge entering RESP and returns a one-cycle response.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE, out of reset)
//   req_we                1 = store, 0 = load
//   req_addr, req_wdata   word address, store data
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata             load data, or the written data for stores
//   rsp_err               address was >= DEPTH
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    // WAIT always spans WAIT_CYCLES+1 cycles, so the array access edge is
    // handshake + WAIT_CYCLES + 1 for every setting including zero.
    localparam logic [CNT_W-1:0] LAST_CNT = WAIT_CYCLES[CNT_W-1:0];

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              handshake;
    logic              enter_resp;
    logic              arr_we;
    logic              arr_in_range;
    logic [DATA_W-1:0] arr_rdata;

    assign req_ready  = rst_n && (state_q == ST_IDLE);
    assign handshake  = req_valid && req_ready;
    assign enter_resp = (state_q == ST_WAIT) && (cnt_q == LAST_CNT);
    // A reset landing on the would-be commit edge discards the store.
    assign arr_we     = enter_resp && we_q && rst_n;

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk      (clk),
        .we       (arr_we),
        .addr     (addr_q),
        .wdata    (wdata_q),
        .rdata    (arr_rdata),
        .in_range (arr_in_range)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end
            end
            ST_WAIT: begin
                if (enter_resp) begin
                    state_d = ST_RESP;
                    err_d   = !arr_in_range;
                    if (!arr_in_range) begin
                        rdata_d = '0;
                    end else if (we_q) begin
                        rdata_d = wdata_q;
                    end else begin
                        rdata_d = arr_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl over four configurations
module tb_dmem_ctrl;

    // 0: 8/8/256 W=2   1: 8/8/256 W=0   2: 8/8/200 W=1   3: 16/10/1024 W=3
    localparam int P_W     [4] = '{2, 0, 1, 3};
    localparam int P_DEPTH [4] = '{256, 256, 200, 1024};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_we;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_err;
    logic [9:0]  req_addr  [4];
    logic [15:0] req_wdata [4];
    logic [7:0]  rd8       [3];
    logic [15:0] rsp_rdata [4];

    always #5 clk = ~clk;

    dmem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0][7:0]), .req_wdata(req_wdata[0][7:0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rd8[0]), .rsp_err(rsp_err[0]));

    dmem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1][7:0]), .req_wdata(req_wdata[1][7:0]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rd8[1]), .rsp_err(rsp_err[1]));

    dmem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(1)) u_d200 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2][7:0]), .req_wdata(req_wdata[2][7:0]),
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rd8[2]), .rsp_err(rsp_err[2]));

    dmem_ctrl #(.DATA_W(16), .ADDR_W(10), .DEPTH(1024), .WAIT_CYCLES(3)) u_wide (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[3]), .req_ready(req_ready[3]),
        .req_we(req_we[3]), .req_addr(req_addr[3]), .req_wdata(req_wdata[3]),
        .rsp_valid(rsp_valid[3]), .rsp_rdata(rsp_rdata[3]), .rsp_err(rsp_err[3]));

    assign rsp_rdata[0] = {8'h00, rd8[0]};
    assign rsp_rdata[1] = {8'h00, rd8[1]};
    assign rsp_rdata[2] = {8'h00, rd8[2]};

    // ---------------- behavioural model ----------------
    int cyc = 0;
    int hs_at   [4] = '{-100, -100, -100, -100};
    int due_at  [4] = '{-100, -100, -100, -100};
    int hs_cnt  [4] = '{0, 0, 0, 0};
    int m_we    [4] = '{0, 0, 0, 0};
    int m_addr  [4] = '{0, 0, 0, 0};
    int m_data  [4] = '{0, 0, 0, 0};
    int exp_rd  [4] = '{0, 0, 0, 0};
    int exp_err [4] = '{0, 0, 0, 0};
    int pulses  [4] = '{0, 0, 0, 0};
    int mem_m [int];
    bit started = 1'b0;
    int n_tests = 0;
    int n_fail  = 0;

    // Busy from the handshake cycle through the response cycle.
    function automatic bit m_ready(input int i, input int c);
        return rst_n && !(c >= hs_at[i] && c <= hs_at[i] + P_W[i] + 1);
    endfunction

    initial begin : model
        int key;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            for (int i = 0; i < 4; i++) begin
                if (!rst_n) begin
                    hs_at[i]   = -100;
                    due_at[i]  = -100;
                    exp_rd[i]  = 0;
                    exp_err[i] = 0;
                end else begin
                    if (cyc == due_at[i]) begin
                        key = i * 4096 + m_addr[i];
                        if (m_addr[i] >= P_DEPTH[i]) begin
                            exp_rd[i]  = 0;
                            exp_err[i] = 1;
                        end else if (m_we[i] != 0) begin
                            mem_m[key] = m_data[i];
                            exp_rd[i]  = m_data[i];
                            exp_err[i] = 0;
                        end else begin
                            exp_rd[i]  = mem_m.exists(key) ? mem_m[key] : 0;
                            exp_err[i] = 0;
                        end
                    end
                    if (req_valid[i] && m_ready(i, cyc - 1)) begin
                        hs_at[i]  = cyc;
                        due_at[i] = cyc + P_W[i] + 1;
                        m_we[i]   = int'(req_we[i]);
                        m_addr[i] = int'(req_addr[i]);
                        m_data[i] = int'(req_wdata[i]);
                        hs_cnt[i] = hs_cnt[i] + 1;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin : compare
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("req_ready[%0d]", i), 32'(req_ready[i]), 32'(m_ready(i, cyc)));
                    check($sformatf("rsp_valid[%0d]", i), 32'(rsp_valid[i]), 32'(cyc == due_at[i]));
                    check($sformatf("rsp_rdata[%0d]", i), 32'(rsp_rdata[i]), exp_rd[i]);
                    check($sformatf("rsp_err[%0d]", i), 32'(rsp_err[i]), exp_err[i]);
                    if (rsp_valid[i]) pulses[i]++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_hs(input int i, input int target, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk);
            #1;
            if (hs_cnt[i] >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check($sformatf("hs_timeout[%0d]", i), 32'd0, 32'd1);
    endtask

    task automatic do_req(input int i, input bit we, input int addr, input int data,
                          output int rd, output int err, output int lat, output int rl);
        bit ok;
        @(negedge clk);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr[9:0];
        req_wdata[i] = data[15:0];
        wait_hs(i, hs_cnt[i] + 1, ok);
        rl = req_ready[i] ? 0 : 1;
        @(negedge clk);
        req_valid[i] = 1'b0;
        lat = 0;
        ok  = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk);
            #1;
            lat++;
            if (!req_ready[i]) rl++;
            if (rsp_valid[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check($sformatf("rsp_timeout[%0d]", i), 32'd0, 32'd1);
        rd  = int'(rsp_rdata[i]);
        err = int'(rsp_err[i]);
        @(posedge clk);
        #1;
        if (!req_ready[i]) rl++;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int rd, er, lat, rl, h1, p0;
        bit ok;
        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        for (int i = 0; i < 4; i++) begin
            req_addr[i]  = '0;
            req_wdata[i] = '0;
        end
        repeat (3) @(posedge clk);
        started = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_ready", 32'(req_ready[0]), 32'd1);
        check("reset_valid", 32'(rsp_valid[0]), 32'd0);
        check("reset_rdata", 32'(rsp_rdata[0]), 32'd0);
        check("reset_err", 32'(rsp_err[3]), 32'd0);

        // W=2 store then load
        do_req(0, 1'b1, 'h10, 'hA5, rd, er, lat, rl);
        check("w2_store_lat", lat, 3);
        check("w2_store_rd", rd, 'hA5);
        check("w2_store_ready_low", rl, 4);
        do_req(0, 1'b0, 'h10, 0, rd, er, lat, rl);
        check("w2_load_rd", rd, 'hA5);
        check("w2_load_err", er, 0);

        // zero wait states
        do_req(1, 1'b1, 3, 'h5A, rd, er, lat, rl);
        check("w0_lat", lat, 1);
        check("w0_ready_low", rl, 2);
        do_req(1, 1'b0, 3, 0, rd, er, lat, rl);
        check("w0_load_rd", rd, 'h5A);

        // out of range, DEPTH = 200
        do_req(2, 1'b1, 199, 'h77, rd, er, lat, rl);
        do_req(2, 1'b1, 200, 'h55, rd, er, lat, rl);
        check("oor_err", er, 1);
        check("oor_rd", rd, 0);
        do_req(2, 1'b0, 199, 0, rd, er, lat, rl);
        check("oor_199_rd", rd, 'h77);
        check("oor_199_err", er, 0);
        do_req(2, 1'b0, 255, 0, rd, er, lat, rl);
        check("oor_load_err", er, 1);

        // width sweep
        do_req(3, 1'b1, 0, 'h1234, rd, er, lat, rl);
        do_req(3, 1'b1, 'h3FF, 'hBEEF, rd, er, lat, rl);
        check("wide_store_lat", lat, 4);
        do_req(3, 1'b0, 'h3FF, 0, rd, er, lat, rl);
        check("wide_load_rd", rd, 'hBEEF);
        do_req(3, 1'b0, 0, 0, rd, er, lat, rl);
        check("wide_addr0_rd", rd, 'h1234);

        // back-to-back: inputs change during WAIT and must be ignored
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 10'h020;
        req_wdata[0] = 16'h0011;
        wait_hs(0, hs_cnt[0] + 1, ok);
        h1 = cyc;
        @(negedge clk);
        req_addr[0]  = 10'h021;
        req_wdata[0] = 16'h0022;
        wait_hs(0, hs_cnt[0] + 1, ok);
        check("b2b_gap", cyc - h1, 5);
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        do_req(0, 1'b0, 'h20, 0, rd, er, lat, rl);
        check("b2b_first_rd", rd, 'h11);
        do_req(0, 1'b0, 'h21, 0, rd, er, lat, rl);
        check("b2b_second_rd", rd, 'h22);

        // reset mid-WAIT discards the pending store
        do_req(0, 1'b1, 'h30, 'h3C, rd, er, lat, rl);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 10'h030;
        req_wdata[0] = 16'h0099;
        wait_hs(0, hs_cnt[0] + 1, ok);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        p0 = pulses[0];
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", 32'(req_ready[0]), 32'd1);
        check("rst_release_rdata", 32'(rsp_rdata[0]), 32'd0);
        check("rst_release_err", 32'(rsp_err[0]), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("rst_no_pulse", pulses[0], p0);
        do_req(0, 1'b0, 'h30, 0, rd, er, lat, rl);
        check("rst_store_discarded", rd, 'h3C);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
